// File: rtl/cpu_pkg.sv
// Shared types and constants for the program loader and its checksum accumulator.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int PROG_LEN = 16;
    localparam int ADDR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOAD,
        ST_CHECK,
        ST_RELEASE,
        ST_ERROR
    } loader_state_t;

    // Checksum is a plain byte sum with 8-bit wraparound.
    function automatic logic [DATA_W-1:0] cksum_add(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/loader_cksum.sv
// 8-bit running checksum of accepted program bytes; clear has priority over enable.
module loader_cksum
    import cpu_pkg::DATA_W, cpu_pkg::cksum_add;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= cksum_add(sum, din);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Halts the CPU, streams a program image into RAM, verifies a trailing checksum
// byte and then releases the CPU through a two-step reset/hold sequence.
module prog_loader
    import cpu_pkg::DATA_W, cpu_pkg::loader_state_t,
           cpu_pkg::ST_IDLE, cpu_pkg::ST_HOLD, cpu_pkg::ST_LOAD,
           cpu_pkg::ST_CHECK, cpu_pkg::ST_RELEASE, cpu_pkg::ST_ERROR;
#(
    parameter int PROG_LEN      = cpu_pkg::PROG_LEN,
    parameter int ADDR_W        = cpu_pkg::ADDR_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(PROG_LEN - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [SET_W-1:0]  settle_cnt;
    logic              rel_step;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] cksum;
    logic              accept;
    logic              wr_accept;

    logic hold_d;
    logic rst_d;
    logic sel_d;
    logic busy_d;
    logic done_d;
    logic error_d;

    // Abort wins over a byte offered in the same cycle.
    assign byte_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign accept     = byte_ready && byte_valid && !load_abort;
    assign wr_accept  = (state == ST_LOAD) && accept;

    loader_cksum u_cksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_HOLD),
        .en    (wr_accept),
        .din   (byte_data),
        .sum   (cksum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            rel_step   <= 1'b0;
            idx        <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == ST_HOLD) ? settle_cnt + 1'b1 : '0;
            rel_step   <= (state == ST_RELEASE);
            if (state == ST_HOLD) begin
                idx <= '0;
            end else if (wr_accept && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_start) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (settle_cnt == SETTLE_LAST) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_abort) begin
                    state_next = ST_ERROR;
                end else if (accept && (idx == LAST_IDX)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (load_abort) begin
                    state_next = ST_ERROR;
                end else if (accept) begin
                    state_next = (byte_data == cksum) ? ST_RELEASE : ST_ERROR;
                end
            end
            ST_RELEASE: begin
                if (rel_step) state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (load_start) state_next = ST_HOLD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops below line up with it.
    always_comb begin
        hold_d  = 1'b0;
        rst_d   = 1'b0;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_next)
            ST_IDLE: begin
                done_d = (state == ST_RELEASE);
            end
            ST_HOLD, ST_LOAD, ST_CHECK: begin
                hold_d = 1'b1;
                rst_d  = 1'b1;
                sel_d  = 1'b1;
                busy_d = 1'b1;
            end
            ST_RELEASE: begin
                hold_d = 1'b1;
                busy_d = 1'b1;
                rst_d  = (state != ST_RELEASE);
            end
            ST_ERROR: begin
                hold_d  = 1'b1;
                rst_d   = 1'b1;
                error_d = 1'b1;
            end
            default: begin
                hold_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold  <= 1'b0;
            cpu_rst   <= 1'b0;
            ram_sel   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            cpu_hold <= hold_d;
            cpu_rst  <= rst_d;
            ram_sel  <= sel_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            ram_we   <= wr_accept;
            if (wr_accept) begin
                ram_addr  <= idx;
                ram_wdata <= byte_data;
            end
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter PROG_LEN, default 16, number of program bytes per load; must equal RAM depth.
REQ-002 Parameter ADDR_W, default 4, RAM address width.
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles between CPU hold and the first RAM write.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 load_start  in  1  request to begin a load; sampled only in IDLE and ERROR.
REQ-007 load_abort  in  1  abandons a load; sampled only in LOAD and CHECK.
REQ-008 byte_valid / byte_data  in  1 / 8  incoming program byte stream.
REQ-009 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-010 cpu_hold  out  1  drives the CPU clock-halt input.
REQ-011 cpu_rst  out  1  holds the CPU control step counter and PC in reset (active-high).
REQ-012 ram_sel  out  1  1 = loader owns the RAM address and data path, 0 = CPU owns it.
REQ-013 ram_addr / ram_wdata / ram_we  out  ADDR_W / 8 / 1  registered RAM write port.
REQ-014 busy / done / error  out  1 / 1 / 1  status; done is a 1-cycle pulse.

Function
REQ-015 FSM states: IDLE, HOLD, LOAD, CHECK, RELEASE, ERROR.
REQ-016 IDLE: all outputs 0; load_start=1 -> HOLD.
REQ-017 HOLD: cpu_hold=cpu_rst=ram_sel=busy=1; wait SETTLE_CYCLES; then -> LOAD with addr counter=0 and checksum=0.
REQ-018 LOAD: byte_ready=1; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-019 Each accepted byte produces ram_we=1 on the next cycle, for exactly one cycle, with ram_addr=index and ram_wdata=byte.
REQ-020 On each accept: checksum updates as checksum+byte mod 256 (8-bit wrap); index increments.
REQ-021 Acceptance of byte PROG_LEN-1 -> CHECK; index does not wrap into a 17th write.
REQ-022 CHECK: byte_ready=1, ram_we=0.
REQ-023 CHECK: accepted byte equal to checksum -> RELEASE; unequal -> ERROR.
REQ-024 RELEASE, cycle 1: ram_sel=0, cpu_rst=1, cpu_hold=1.
REQ-025 RELEASE, cycle 2: cpu_rst=0, cpu_hold=1.
REQ-026 After RELEASE: -> IDLE with cpu_hold=0 and done=1 for that one cycle.
REQ-027 ERROR: cpu_hold=cpu_rst=1, ram_sel=0, error=1, busy=0.
REQ-028 ERROR: load_start=1 -> HOLD and clears error.
REQ-029 load_abort=1 in LOAD or CHECK -> ERROR next cycle; the byte offered in that same cycle is not accepted (abort wins).
REQ-030 load_start outside IDLE/ERROR and load_abort outside LOAD/CHECK are ignored.
REQ-031 byte_ready is combinational from state only, never from byte_valid.
REQ-032 byte_valid gaps of any length stall the load with no timeout.

Reset
REQ-033 rst_n=0 forces IDLE at once and clears index, checksum and all outputs to 0, including mid-load.
REQ-034 An interrupted load leaves the RAM contents undefined.
REQ-035 After rst_n rises, the first possible state change occurs on the first posedge.

Structure
REQ-036 Shared package cpu_pkg holds the loader_state_t enum, PROG_LEN, ADDR_W and the 8-bit data width constant.
REQ-037 One sub-module, loader_cksum: an 8-bit accumulator with clear and enable, instantiated once.
REQ-038 ram_sel, cpu_hold and cpu_rst are driven directly from flops (glitch-free); the RAM-side mux lives outside this block.

Verification
REQ-039 Good load: start, bytes 0x00..0x0F back-to-back, then checksum 0x78 -> 16 writes with addr=i, data=i; done pulses once; cpu_hold=0 afterwards.
REQ-040 Bad checksum: same bytes, then checksum 0x00 -> error=1, cpu_rst=1, no done; load_start then repeats the good load successfully.
REQ-041 Backpressure: byte_valid alternating 1/0 and 3-cycle gaps -> same 16 writes in order; exactly one ram_we per accepted byte.
REQ-042 Wrap: 16 bytes of 0xFF, checksum 0xF0 -> RELEASE and done.
REQ-043 Reset mid-load: rst_n=0 after 5 bytes -> all outputs 0 on the same cycle; a fresh load_start completes normally.
REQ-044 Abort: load_abort with byte_valid=1 at byte 7 -> ERROR, no write at addr 7; load_start during LOAD ignored.
